// File: rtl/ysyx_pkg.sv
// Shared IFU definitions: FSM encoding, field-width helper and default L1I line geometry.
package ysyx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_OUT    = 2'd3
  } ifu_state_t;

  localparam int BYTE_OFF_W     = 2;
  localparam int L1I_LINE_WORDS = 4;
  localparam int L1I_SETS       = 16;

  // Width of a field that selects one of n items; never zero so it can size a vector.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_ifu_l1i_if.sv
// Single-beat instruction memory read bus between the IFU (master) and memory (slave).
interface ysyx_ifu_l1i_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_araddr_o;
  logic              ifu_arvalid_o;
  logic              ifu_arready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;

  modport master (output ifu_araddr_o, ifu_arvalid_o, input ifu_arready, ifu_rdata, ifu_rvalid);
  modport slave  (input ifu_araddr_o, ifu_arvalid_o, output ifu_arready, ifu_rdata, ifu_rvalid);
endinterface

// File: rtl/ysyx_l1i_array.sv
// Direct-mapped L1I storage: async read of (idx,off), one word write, tag/valid set, global flush.
module ysyx_l1i_array
  import ysyx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 26,
  parameter int LINE_WORDS = L1I_LINE_WORDS,
  parameter int SETS       = L1I_SETS,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = field_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic              flush
);

  localparam int WA_W = $clog2(SETS * LINE_WORDS);

  logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [WA_W-1:0]   rd_wa;
  logic [WA_W-1:0]   wr_wa;

  assign rd_wa    = WA_W'(rd_idx) * WA_W'(LINE_WORDS) + WA_W'(rd_off);
  assign wr_wa    = WA_W'(wr_idx) * WA_W'(LINE_WORDS) + WA_W'(wr_off);
  assign rd_data  = data_mem[rd_wa];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // NOTE: data and tag arrays are deliberately not reset; valid_q alone gates their use.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_wa] <= wr_data;
    if (set_en) tag_mem[set_idx] <= set_tag;
  end

  // Flush takes priority so a fence coinciding with a line fill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst || flush)  valid_q <= '0;
    else if (set_en)   valid_q[set_idx] <= 1'b1;
  end

endmodule

// File: rtl/ysyx_ifu_l1i.sv
// Instruction fetch unit: PC accept, L1I lookup, whole-line refill over a single-beat bus, perf counters.
module ysyx_ifu_l1i
  import ysyx_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = L1I_LINE_WORDS,
  parameter int SETS       = L1I_SETS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prev_valid,
  output logic               ready_o,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  input  logic               next_ready,
  output logic [DATA_W-1:0]  inst_o,
  output logic [ADDR_W-1:0]  pc_o,
  input  logic               fence_i,
  ysyx_ifu_l1i_if.master     mem,
  output logic [31:0]        perf_hit_o,
  output logic [31:0]        perf_miss_o
);

  localparam int OFF_B   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int OFF_W   = field_w(LINE_WORDS);
  localparam int LINE_SH = BYTE_OFF_W + OFF_B;
  localparam int TAG_W   = ADDR_W - LINE_SH - IDX_W;

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, araddr_q;
  logic [DATA_W-1:0] inst_q;
  logic              arvalid_q, wait_q, flushed_q;
  logic [OFF_W-1:0]  beat_q;
  logic [31:0]       hit_q, miss_q;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, hit, rvalid_ok, last_beat, set_en;

  if (LINE_WORDS > 1) begin : g_off
    assign off = pc_q[LINE_SH-1:BYTE_OFF_W];
  end else begin : g_no_off
    assign off = '0;
  end
  assign idx = pc_q[LINE_SH+IDX_W-1:LINE_SH];
  assign tag = pc_q[ADDR_W-1:LINE_SH+IDX_W];

  // A fence in the lookup cycle forces a miss so a line being flushed is never served.
  assign hit       = rd_valid && (rd_tag == tag) && !fence_i;
  assign rvalid_ok = (state_q == ST_REFILL) && wait_q && mem.ifu_rvalid;
  assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));
  assign set_en    = rvalid_ok && last_beat && !flushed_q && !fence_i;

  ysyx_l1i_array #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_off  (off),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .rd_valid(rd_valid),
    .wr_en   (rvalid_ok),
    .wr_idx  (idx),
    .wr_off  (beat_q),
    .wr_data (mem.ifu_rdata),
    .set_en  (set_en),
    .set_idx (idx),
    .set_tag (tag),
    .flush   (fence_i)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (prev_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = hit ? ST_OUT : ST_REFILL;
      ST_REFILL: if (rvalid_ok && last_beat) state_d = ST_OUT;
      ST_OUT:    if (next_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      inst_q    <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      wait_q    <= 1'b0;
      flushed_q <= 1'b0;
      beat_q    <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (prev_valid) pc_q <= pc_i;
        ST_LOOKUP: begin
          flushed_q <= 1'b0;
          beat_q    <= '0;
          wait_q    <= 1'b0;
          if (hit) begin
            inst_q <= rd_data;
            hit_q  <= hit_q + 32'd1;
          end else begin
            miss_q    <= miss_q + 32'd1;
            araddr_q  <= {pc_q[ADDR_W-1:LINE_SH], {LINE_SH{1'b0}}};
            arvalid_q <= 1'b1;
          end
        end
        ST_REFILL: begin
          if (fence_i) flushed_q <= 1'b1;
          if (arvalid_q && mem.ifu_arready) begin
            arvalid_q <= 1'b0;
            wait_q    <= 1'b1;
          end
          if (rvalid_ok) begin
            wait_q <= 1'b0;
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == off) inst_q <= mem.ifu_rdata;
            if (!last_beat) begin
              arvalid_q <= 1'b1;
              araddr_q  <= araddr_q + ADDR_W'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o           = (state_q == ST_IDLE);
  assign valid_o           = (state_q == ST_OUT);
  assign inst_o            = inst_q;
  assign pc_o              = pc_q;
  assign mem.ifu_araddr_o  = araddr_q;
  assign mem.ifu_arvalid_o = arvalid_q;
  assign perf_hit_o        = hit_q;
  assign perf_miss_o       = miss_q;

endmodule

// File: tb/tb_ysyx_ifu_l1i.sv
// Directed bench for ysyx_ifu_l1i: scoreboarded fetches against a behavioural single-beat memory.
module tb_ysyx_ifu_l1i;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int SETS       = 16;

  logic        clk = 1'b0;
  logic        rst, prev_valid, next_ready, fence_main, fence_rsp, fence_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_i, inst_o, pc_o, perf_hit_o, perf_miss_o;

  ysyx_ifu_l1i_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  assign fence_i = fence_main | fence_rsp;

  ysyx_ifu_l1i #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (prev_valid),
    .ready_o    (ready_o),
    .pc_i       (pc_i),
    .valid_o    (valid_o),
    .next_ready (next_ready),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .fence_i    (fence_i),
    .mem        (mem_if),
    .perf_hit_o (perf_hit_o),
    .perf_miss_o(perf_miss_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] exp_addr[$];
  int checks = 0, failures = 0;
  int stall_cfg = 0, rsp_delay = 0, fence_on_rsp = -1;
  int req_count = 0, rsp_count = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E ^ {a[7:0], 24'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: optional arready stall, rvalid rsp_delay cycles after acceptance,
  // optional fence_i pulse coincident with a chosen rvalid beat.
  initial begin
    int          stall_cnt;
    int          pend;
    logic [31:0] pend_addr;
    stall_cnt = 0;
    pend      = 0;
    pend_addr = '0;
    mem_if.ifu_arready = 1'b0;
    mem_if.ifu_rvalid  = 1'b0;
    mem_if.ifu_rdata   = '0;
    fence_rsp          = 1'b0;
    forever begin
      @(negedge clk);
      mem_if.ifu_arready = 1'b0;
      mem_if.ifu_rvalid  = 1'b0;
      fence_rsp          = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_if.ifu_rvalid = 1'b1;
          mem_if.ifu_rdata  = mem_word(pend_addr);
          if (rsp_count == fence_on_rsp) fence_rsp = 1'b1;
          rsp_count++;
        end
      end else if (mem_if.ifu_arvalid_o) begin
        if (exp_addr.size() == 0) check("req_unexpected", {63'd0, mem_if.ifu_arvalid_o}, 64'd0);
        else                      check("araddr", {32'd0, mem_if.ifu_araddr_o}, {32'd0, exp_addr[0]});
        if (stall_cnt < stall_cfg) begin
          stall_cnt++;
        end else begin
          mem_if.ifu_arready = 1'b1;
          stall_cnt = 0;
          pend      = rsp_delay + 1;
          pend_addr = mem_if.ifu_araddr_o;
          req_count++;
          if (exp_addr.size() > 0) void'(exp_addr.pop_front());
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input bit miss, input int hold);
    int     lat;
    int     req0;
    fetch_t e;
    e.pc   = pc;
    e.inst = mem_word({pc[31:2], 2'b00});
    exp_q.push_back(e);
    if (miss)
      for (int b = 0; b < LINE_WORDS; b++) exp_addr.push_back({pc[31:4], 4'h0} + 32'(b * 4));
    req0 = req_count;
    check("ready_before_accept", {63'd0, ready_o}, 64'd1);
    next_ready = (hold == 0);
    prev_valid = 1'b1;
    pc_i       = pc;
    @(negedge clk);
    prev_valid = 1'b0;
    pc_i       = ~pc;
    lat = 1;
    while (!valid_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("valid_o", {63'd0, valid_o}, 64'd1);
    if (!miss) begin
      check("hit_latency", 64'(lat), 64'd2);
      check("hit_no_req", 64'(req_count - req0), 64'd0);
    end else begin
      check("miss_reqs", 64'(req_count - req0), 64'(LINE_WORDS));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, valid_o}, 64'd1);
      check("hold_ready", {63'd0, ready_o}, 64'd0);
      check("hold_pc", {32'd0, pc_o}, {32'd0, exp_q[0].pc});
      check("hold_inst", {32'd0, inst_o}, {32'd0, exp_q[0].inst});
    end
    e = exp_q.pop_front();
    check("pc_o", {32'd0, pc_o}, {32'd0, e.pc});
    check("inst_o", {32'd0, inst_o}, {32'd0, e.inst});
    next_ready = 1'b1;
    @(negedge clk);
    check("retire_valid", {63'd0, valid_o}, 64'd0);
    check("retire_ready", {63'd0, ready_o}, 64'd1);
  endtask

  task automatic check_perf(input int hits, input int misses);
    check("perf_hit", {32'd0, perf_hit_o}, 64'(hits));
    check("perf_miss", {32'd0, perf_miss_o}, 64'(misses));
  endtask

  initial begin
    int n;
    int req0;
    int rsp0;
    rst        = 1'b1;
    prev_valid = 1'b0;
    next_ready = 1'b1;
    pc_i       = '0;
    fence_main = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_arvalid", {63'd0, mem_if.ifu_arvalid_o}, 64'd0);
    check("rst_araddr", {32'd0, mem_if.ifu_araddr_o}, 64'd0);
    check("rst_inst", {32'd0, inst_o}, 64'd0);
    check("rst_pc", {32'd0, pc_o}, 64'd0);
    check_perf(0, 0);

    // Cold miss, then a hit in the same line.
    fetch(32'h8000_0004, 1'b1, 0);
    check_perf(0, 1);
    fetch(32'h8000_000C, 1'b0, 0);
    check_perf(1, 1);

    // Fence in IDLE, then conflicting tags on set 0.
    fence_main = 1'b1;
    @(negedge clk);
    fence_main = 1'b0;
    fetch(32'h8000_0000, 1'b1, 0);
    fetch(32'h8000_0100, 1'b1, 0);
    fetch(32'h8000_0000, 1'b1, 0);
    check_perf(1, 4);

    // Backpressure on both the bus and the downstream handshake.
    stall_cfg = 3;
    fetch(32'h8000_0014, 1'b1, 5);
    stall_cfg = 0;
    fetch(32'h8000_0018, 1'b0, 3);
    check_perf(2, 5);

    // Fence mid-refill and fence with the last beat: delivered, but not retained.
    fetch(32'h8000_0100, 1'b1, 0);
    fence_on_rsp = rsp_count + 1;
    fetch(32'h8000_0008, 1'b1, 0);
    fence_on_rsp = -1;
    fetch(32'h8000_0008, 1'b1, 0);
    fence_on_rsp = rsp_count + 3;
    fetch(32'h8000_0024, 1'b1, 0);
    fence_on_rsp = -1;
    fetch(32'h8000_0024, 1'b1, 0);
    fetch(32'h8000_0024, 1'b0, 0);
    fetch(32'h8000_0014, 1'b1, 0);
    check_perf(3, 11);

    // Reset while the third beat is outstanding; its rvalid arrives after reset.
    rsp_delay = 4;
    req0 = req_count;
    rsp0 = rsp_count;
    for (int b = 0; b < LINE_WORDS; b++) exp_addr.push_back(32'h8000_0300 + 32'(b * 4));
    prev_valid = 1'b1;
    pc_i       = 32'h8000_0300;
    @(negedge clk);
    prev_valid = 1'b0;
    n = 0;
    while (req_count < req0 + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reqs", 64'(req_count - req0), 64'd3);
    check("rst_mid_rsps", 64'(rsp_count - rsp0), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_arvalid", {63'd0, mem_if.ifu_arvalid_o}, 64'd0);
    check("rst_mid_ready", {63'd0, ready_o}, 64'd1);
    check("rst_mid_araddr", {32'd0, mem_if.ifu_araddr_o}, 64'd0);
    check_perf(0, 0);
    repeat (6) @(negedge clk);
    check("late_rvalid_seen", 64'(rsp_count - rsp0), 64'd3);
    check("late_rvalid_ready", {63'd0, ready_o}, 64'd1);
    check("late_rvalid_valid", {63'd0, valid_o}, 64'd0);
    exp_addr.delete();
    rsp_delay = 0;
    fetch(32'h8000_0300, 1'b1, 0);
    fetch(32'h8000_0008, 1'b1, 0);
    check_perf(0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
